avmm_cfg_slave: RTL
===================

Name: avmm_cfg_slave

Overview:
Avalon-MM responder that terminates the configuration write traffic issued by the config sequencer. It holds a bank of 32-bit configuration registers plus one read-only status word. Each access is stretched by a parameterised number of wait states using avmm_waitrequest. Writes are applied with per-byte enables, reads return data in the acknowledge cycle, and register contents are exposed as a flat vector for downstream AIB/AXI-Lite logic.

Parameters:
NUM_REGS, 32, number of read/write config registers (1..64)
BASE_ADDR, 17'h0, byte base address of register window (word aligned)
WAIT_STATES, 1, extra cycles waitrequest stays high before acknowledge (0..15)
RESET_VALUE, 32'h0, reset value of every config register

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
avmm_address  input  17  byte address
avmm_writedata  input  32  write data
avmm_byteenable  input  4  byte lanes for writes
avmm_write  input  1  write request
avmm_read  input  1  read request
avmm_waitrequest  output  1  stall; low for exactly the acknowledge cycle
avmm_readdata  output  32  read data, valid when avmm_readdatavalid=1
avmm_readdatavalid  output  1  one-cycle pulse in read acknowledge cycle
status_in  input  32  read-only status word, at word offset NUM_REGS
clr_err  input  1  clears err_sticky
cfg_regs  output  NUM_REGS*32  register contents; reg k at bits [32k+31:32k]
cfg_wr_pulse  output  NUM_REGS  one-cycle pulse the cycle after reg k is written
err_sticky  output  1  set on decode or protocol error

Behaviour:
- Reset values (async, rst_n=0): waitrequest=1; readdata=0; readdatavalid=0; regs=RESET_VALUE; cfg_wr_pulse=0; err_sticky=0; FSM=IDLE; wait counter=0.
- waitrequest is registered and is high in every state except ACK.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if write or read is high, load counter=WAIT_STATES. Go to ACK if WAIT_STATES=0, otherwise WAIT.
  - WAIT: decrement the counter. When counter==1, go to ACK. If write and read both drop, go to IDLE (abort, no side effects).
  - ACK: waitrequest=0 for exactly one cycle. The transfer completes on this clock edge. Return to IDLE.
- Latency: request first seen in cycle 0; ACK occurs in cycle WAIT_STATES+1. Back-to-back transfers are separated by at least one IDLE cycle.
- Address, writedata and byteenable are sampled in the ACK cycle only.
- Decode:
  - word offset = (avmm_address - BASE_ADDR) >> 2.
  - Offset < NUM_REGS with address[1:0]==0: config register.
  - Offset == NUM_REGS: status.
  - Anything else: out of range.
- Write commit at ACK edge: for each lane b with byteenable[b]=1, reg[8b+7:8b] <= writedata[8b+7:8b]. byteenable=0 is a legal no-op write and still pulses cfg_wr_pulse. cfg_wr_pulse[k] is high the following cycle.
- Writes to status or out-of-range addresses: ignored, err_sticky set; the write is still acknowledged (never hangs the master).
- Read at ACK: readdatavalid=1; readdata = register, status_in (sampled in ACK), or 32'hDEAD_BEEF if out of range (also sets err_sticky). readdata holds its value after the pulse until the next read.
- write and read both high at request or ACK: protocol error. Write takes priority, err_sticky set, and readdatavalid stays 0.
- clr_err and a new error in the same cycle: set wins.
- Reset mid-transfer: immediate return to IDLE, registers reinitialised, nothing is committed.

Decomposition:
- Package avmm_cfg_pkg:
  - AVMM_ADDR_W=17, AVMM_DATA_W=32, AVMM_BE_W=4
  - state enum {IDLE, WAIT, ACK}
  - DECODE_ERR_DATA=32'hDEAD_BEEF
  - function for byte-lane merge
- Sub-module avmm_cfg_regbank: register storage, byte-enable merge, cfg_wr_pulse generation. The top level holds the FSM, wait counter and decode.

Test Plan:
- WAIT_STATES=1, write addr 17'h8, data 32'hA5A5_1234, be 4'hF: waitrequest low in cycle 2; cfg_regs reg2=32'hA5A5_1234; cfg_wr_pulse[2] high in cycle 3.
- Reg2=32'hA5A5_1234, write 32'hFFFF_FFFF with be 4'b0101: reg2=32'hA5FF_12FF; a read of 17'h8 returns that value with readdatavalid high for one cycle.
- Read offset NUM_REGS with status_in=32'h0000_00C3: readdata=32'h0000_00C3, err_sticky=0. A write to the same address leaves it unchanged and sets err_sticky=1. Asserting clr_err clears it.
- Read 17'h1_0000 (out of range): readdata=32'hDEAD_BEEF, err_sticky=1. Write and read asserted together: write commits, readdatavalid stays 0, err_sticky=1.
- WAIT_STATES=3, drop avmm_write in cycle 2: no ACK, no register change, FSM back in IDLE. Repeat with rst_n pulsed low in WAIT: all regs=RESET_VALUE, waitrequest=1.
- Sequencer-style burst of three writes to offsets 0, 1, 2 through the config sequencer model: all three acknowledged with waitrequest behaving as specified, and the correct cfg_wr_pulse bits fire in order.

Source files
------------

// File: rtl/avmm_cfg_pkg.sv
// Shared widths, FSM state type and byte-lane helper for the Avalon-MM config responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avmm_cfg_pkg;

    localparam int AVMM_ADDR_W = 17;
    localparam int AVMM_DATA_W = 32;
    localparam int AVMM_BE_W   = 4;

    // Returned on reads that hit neither a config register nor the status word
    localparam logic [AVMM_DATA_W-1:0] DECODE_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    // Replace only the byte lanes whose enable bit is set
    function automatic logic [AVMM_DATA_W-1:0] byte_merge(
        input logic [AVMM_DATA_W-1:0] old_val,
        input logic [AVMM_DATA_W-1:0] new_val,
        input logic [AVMM_BE_W-1:0]   be
    );
        logic [AVMM_DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < AVMM_BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/avmm_cfg_regbank.sv
// Config register storage with byte-lane writes and a per-register write strobe.
// Latency: write visible on cfg_regs and cfg_wr_pulse one cycle after wr_en.
// Backpressure: none; accepts a write every cycle wr_en is high.
module avmm_cfg_regbank
    import avmm_cfg_pkg::*;
#(
    parameter int                     NUM_REGS    = 32,
    parameter int                     IDX_W       = 5,
    parameter logic [AVMM_DATA_W-1:0] RESET_VALUE = 32'h0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [AVMM_DATA_W-1:0]          wr_data,
    input  logic [AVMM_BE_W-1:0]            wr_be,
    output logic [NUM_REGS*AVMM_DATA_W-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]             cfg_wr_pulse
);

    logic [AVMM_DATA_W-1:0] regs_q [NUM_REGS];

    // Register array: reset to RESET_VALUE, byte-merge on write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VALUE;
            end
        end else if (wr_en) begin
            regs_q[wr_idx] <= byte_merge(regs_q[wr_idx], wr_data, wr_be);
        end
    end

    // One-hot strobe for the register just written (fires even with no lanes enabled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_wr_pulse <= '0;
        end else if (wr_en) begin
            cfg_wr_pulse <= NUM_REGS'(1) << wr_idx;
        end else begin
            cfg_wr_pulse <= '0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign cfg_regs[g*AVMM_DATA_W +: AVMM_DATA_W] = regs_q[g];
        end
    endgenerate

endmodule

// File: rtl/avmm_cfg_slave.sv
// Avalon-MM config responder: register bank, read-only status word, sticky error flag.
// Latency: acknowledge (waitrequest low) in cycle WAIT_STATES+1 after the request appears.
// Backpressure: waitrequest held high until the single ACK cycle; aborts if the request drops.
module avmm_cfg_slave
    import avmm_cfg_pkg::*;
#(
    parameter int                     NUM_REGS    = 32,
    parameter logic [AVMM_ADDR_W-1:0] BASE_ADDR   = 17'h0,
    parameter int                     WAIT_STATES = 1,
    parameter logic [AVMM_DATA_W-1:0] RESET_VALUE = 32'h0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [AVMM_ADDR_W-1:0]          avmm_address,
    input  logic [AVMM_DATA_W-1:0]          avmm_writedata,
    input  logic [AVMM_BE_W-1:0]            avmm_byteenable,
    input  logic                            avmm_write,
    input  logic                            avmm_read,
    output logic                            avmm_waitrequest,
    output logic [AVMM_DATA_W-1:0]          avmm_readdata,
    output logic                            avmm_readdatavalid,
    input  logic [AVMM_DATA_W-1:0]          status_in,
    input  logic                            clr_err,
    output logic [NUM_REGS*AVMM_DATA_W-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]             cfg_wr_pulse,
    output logic                            err_sticky
);

    localparam int                     IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AVMM_ADDR_W-1:0] STATUS_OFS = AVMM_ADDR_W'(NUM_REGS);
    localparam logic [3:0]             WS_INIT    = 4'(WAIT_STATES);

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic                   req;
    logic                   rd_only;
    logic                   enter_ack;
    logic [AVMM_ADDR_W-1:0] addr_rel;
    logic [AVMM_ADDR_W-1:0] word_ofs;
    logic                   hit_reg;
    logic                   hit_status;
    logic [IDX_W-1:0]       reg_idx;
    logic [AVMM_DATA_W-1:0] rd_mux;
    logic                   wr_commit;
    logic                   err_set;

    assign req     = avmm_write | avmm_read;
    assign rd_only = avmm_read & ~avmm_write;

    // Address decode; BASE_ADDR is word aligned so the low bits of addr_rel match the raw address
    assign addr_rel   = avmm_address - BASE_ADDR;
    assign word_ofs   = {2'b00, addr_rel[AVMM_ADDR_W-1:2]};
    assign hit_reg    = (word_ofs < STATUS_OFS) && (addr_rel[1:0] == 2'b00);
    assign hit_status = (word_ofs == STATUS_OFS);
    assign reg_idx    = word_ofs[IDX_W-1:0];

    // Read source selection
    always_comb begin
        rd_mux = DECODE_ERR_DATA;
        if (hit_reg) begin
            rd_mux = cfg_regs[reg_idx*AVMM_DATA_W +: AVMM_DATA_W];
        end else if (hit_status) begin
            rd_mux = status_in;
        end
    end

    // The edge that moves the FSM into ACK; the master holds its request stable
    // while waitrequest is high, so values seen here are those present during ACK.
    assign enter_ack = req && (((state == IDLE) && (WAIT_STATES == 0)) ||
                               ((state == WAIT) && (wait_cnt == 4'd1)));

    // Handshake FSM with registered waitrequest and read data outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            wait_cnt           <= 4'd0;
            avmm_waitrequest   <= 1'b1;
            avmm_readdata      <= '0;
            avmm_readdatavalid <= 1'b0;
        end else begin
            avmm_waitrequest   <= ~enter_ack;
            avmm_readdatavalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        wait_cnt <= WS_INIT;
                        state    <= (WAIT_STATES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state    <= IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (enter_ack && rd_only) begin
                avmm_readdatavalid <= 1'b1;
                avmm_readdata      <= rd_mux;
            end
        end
    end

    // Writes land on the ACK edge; write wins when read is also asserted
    assign wr_commit = (state == ACK) && avmm_write && hit_reg;

    // Errors: simultaneous read+write at request or ACK, writes outside the
    // register window, reads that hit nothing
    assign err_set = (((state == IDLE) || (state == ACK)) && avmm_write && avmm_read) ||
                     ((state == ACK) && avmm_write && !hit_reg) ||
                     ((state == ACK) && rd_only && !hit_reg && !hit_status);

    // Sticky error flag; a new error beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

    avmm_cfg_regbank #(
        .NUM_REGS    (NUM_REGS),
        .IDX_W       (IDX_W),
        .RESET_VALUE (RESET_VALUE)
    ) u_regbank (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_commit),
        .wr_idx       (reg_idx),
        .wr_data      (avmm_writedata),
        .wr_be        (avmm_byteenable),
        .cfg_regs     (cfg_regs),
        .cfg_wr_pulse (cfg_wr_pulse)
    );

endmodule
